// File: rtl/jtcps1_pkg.sv
// Shared constants and FSM state encoding for the CPS1 palette copy engine.
package jtcps1_pkg;

  localparam int PAL_PAGE_WORDS = 512;
  localparam int PAL_BASE_SHIFT = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    WR   = 3'd4,
    FIN  = 3'd5
  } pal_state_t;

endpackage

// File: rtl/jtcps1_pal_pagesel.sv
// Combinational finder for the lowest enabled palette page at or above the current page.
module jtcps1_pal_pagesel #(
  parameter int PAGES = 6,
  parameter int PGW   = 3
) (
  input  logic [PAGES-1:0] mask,
  input  logic [PGW:0]     cur,
  output logic [PGW-1:0]   page,
  output logic             valid
);

  // Scan downwards so the lowest qualifying page is the last one to win
  always_comb begin
    page  = '0;
    valid = 1'b0;
    for (int i = PAGES - 1; i >= 0; i--) begin
      logic hit;
      hit   = mask[i] && ((PGW+1)'(i) >= cur);
      page  = hit ? PGW'(i) : page;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/jtcps1_pal_dma.sv
// Palette copy engine: moves enabled 512-word palette pages from VRAM into palette RAM.
// Build option JTCPS1_PAL_BLANK_EN: disabled pages are zero-filled instead of skipped.
module jtcps1_pal_dma
  import jtcps1_pkg::*;
#(
  parameter int PAGES = 6,
  parameter int PGW   = 3,
  parameter int IDXW  = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         pal_base,
  input  logic [PAGES-1:0]    pal_page_en,
  input  logic                pal_copy,
  output logic                busy,
  output logic                done,
  output logic [16:0]         vram_addr,
  input  logic [15:0]         vram_data,
  input  logic                vram_ok,
  output logic                vram_cs,
  output logic [PGW+IDXW-1:0] pal_addr,
  output logic [15:0]         pal_data,
  output logic                pal_we
);

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(PAL_PAGE_WORDS - 1);

  pal_state_t       state;
  logic             copy_last;
  logic             copy_edge;
  logic             pending;
  logic [PAGES-1:0] mask_sh;
  logic [PAGES-1:0] sel_mask;
  logic [PGW:0]     cur_page;
  logic [PGW-1:0]   sel_page;
  logic             sel_valid;
  logic [IDXW-1:0]  idx;
  logic [16:0]      src;
  logic [16:0]      base_addr;
  logic             unused_base;

  assign copy_edge   = pal_copy & ~copy_last;
  assign base_addr   = {pal_base[9:0], {PAL_BASE_SHIFT{1'b0}}};
  assign unused_base = ^pal_base[15:10];

`ifdef JTCPS1_PAL_BLANK_EN
  logic blank;
  // Every page is visited; the shadow mask only decides fetch versus zero-fill
  assign sel_mask = '1;
`else
  assign sel_mask = mask_sh;
`endif

  jtcps1_pal_pagesel #(
    .PAGES (PAGES),
    .PGW   (PGW)
  ) u_pagesel (
    .mask  (sel_mask),
    .cur   (cur_page),
    .page  (sel_page),
    .valid (sel_valid)
  );

  // Copy sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      copy_last <= 1'b0;
      pending   <= 1'b0;
      mask_sh   <= '0;
      cur_page  <= '0;
      idx       <= '0;
      src       <= 17'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vram_addr <= 17'd0;
      vram_cs   <= 1'b0;
      pal_addr  <= '0;
      pal_data  <= 16'h0000;
      pal_we    <= 1'b0;
`ifdef JTCPS1_PAL_BLANK_EN
      blank     <= 1'b0;
`endif
    end else begin
      copy_last <= pal_copy;
      done      <= 1'b0;
      pal_we    <= 1'b0;
      if (copy_edge && (state != IDLE) && (state != FIN)) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (copy_edge) begin
            mask_sh  <= pal_page_en;
            src      <= base_addr;
            cur_page <= '0;
            busy     <= 1'b1;
            state    <= SEL;
          end
        end
        SEL: begin
          if (sel_valid) begin
            cur_page <= {1'b0, sel_page};
            idx      <= '0;
`ifdef JTCPS1_PAL_BLANK_EN
            if (mask_sh[sel_page]) begin
              vram_addr <= src;
              vram_cs   <= 1'b1;
              state     <= REQ;
            end else begin
              blank    <= 1'b1;
              pal_addr <= {sel_page, {IDXW{1'b0}}};
              pal_data <= 16'h0000;
              pal_we   <= 1'b1;
              state    <= WR;
            end
`else
            vram_addr <= src;
            vram_cs   <= 1'b1;
            state     <= REQ;
`endif
          end else begin
            done    <= 1'b1;
            busy    <= 1'b0;
            vram_cs <= 1'b0;
            state   <= FIN;
          end
        end
        // Address settles for a cycle so a stale ok from the previous word is ignored
        REQ: state <= WAIT;
        WAIT: begin
          if (vram_ok) begin
            pal_data <= vram_data;
            pal_addr <= {cur_page[PGW-1:0], idx};
            pal_we   <= 1'b1;
            vram_cs  <= 1'b0;
            state    <= WR;
          end
        end
        WR: begin
`ifdef JTCPS1_PAL_BLANK_EN
          if (blank) begin
            if (idx == IDX_LAST) begin
              blank    <= 1'b0;
              cur_page <= cur_page + (PGW+1)'(1);
              state    <= SEL;
            end else begin
              idx      <= idx + IDXW'(1);
              pal_addr <= {cur_page[PGW-1:0], idx + IDXW'(1)};
              pal_data <= 16'h0000;
              pal_we   <= 1'b1;
            end
          end else
`endif
          begin
            src <= src + 17'd1;
            if (idx == IDX_LAST) begin
              cur_page <= cur_page + (PGW+1)'(1);
              state    <= SEL;
            end else begin
              idx       <= idx + IDXW'(1);
              vram_addr <= src + 17'd1;
              vram_cs   <= 1'b1;
              state     <= REQ;
            end
          end
        end
        // A request arriving on this cycle restarts directly without a trip through IDLE
        FIN: begin
          if (pending || copy_edge) begin
            pending  <= pending & copy_edge;
            mask_sh  <= pal_page_en;
            src      <= base_addr;
            cur_page <= '0;
            busy     <= 1'b1;
            state    <= SEL;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcps1_pal_dma.sv
// Scoreboard bench for jtcps1_pal_dma: random VRAM contents and ok latency, expected writes
// derived from the page/base rules. Honors JTCPS1_PAL_BLANK_EN when defined.
module tb_jtcps1_pal_dma;

  localparam int PAGES = 6;
  localparam int PGW   = 3;
  localparam int IDXW  = 9;

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      pal_base;
  logic [PAGES-1:0] pal_page_en;
  logic             pal_copy;
  logic             busy, done;
  logic [16:0]      vram_addr;
  logic [15:0]      vram_data;
  logic             vram_ok;
  logic             vram_cs;
  logic [11:0]      pal_addr;
  logic [15:0]      pal_data;
  logic             pal_we;

  logic [15:0] vmem [0:131071];
  wr_t         exp_q[$];
  int tests = 0, fails = 0;
  int done_exp = 0, done_cnt = 0, words_seen = 0, cs_cnt = 0;
  int ok_min = 1, ok_max = 1;
  logic        mon_cs = 1'b0, r_cs = 1'b0;
  logic [16:0] mon_addr = 17'd0, r_addr = 17'd0;

  jtcps1_pal_dma #(.PAGES(PAGES), .PGW(PGW), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .pal_base(pal_base), .pal_page_en(pal_page_en),
    .pal_copy(pal_copy), .busy(busy), .done(done), .vram_addr(vram_addr),
    .vram_data(vram_data), .vram_ok(vram_ok), .vram_cs(vram_cs),
    .pal_addr(pal_addr), .pal_data(pal_data), .pal_we(pal_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: walk pages in order, enabled pages consume consecutive VRAM words
  task automatic push_copy();
    logic [16:0] src;
    wr_t e;
    src = {pal_base[9:0], 7'd0};
    for (int p = 0; p < PAGES; p++) begin
      for (int i = 0; i < 512; i++) begin
        e.addr = {3'(p), 9'(i)};
        if (pal_page_en[p]) begin
          e.data = vmem[src];
          src = src + 17'd1;
          exp_q.push_back(e);
        end
`ifdef JTCPS1_PAL_BLANK_EN
        else begin
          e.data = 16'h0000;
          exp_q.push_back(e);
        end
`endif
      end
    end
    done_exp++;
  endtask

  task automatic start_copy();
    @(negedge clk);
    pal_copy = 1'b1;
    @(negedge clk);
    pal_copy = 1'b0;
  endtask

  task automatic wait_words(input int target);
    int n = 0;
    while (words_seen < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("word_wait_timeout", 64'(n >= 20000), 64'd0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || done_exp != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 64'(n >= budget), 64'd0);
    repeat (30) @(negedge clk);
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // VRAM responder: ok after a random number of cycles per new address
  initial begin
    int cnt, dly;
    cnt = 0;
    dly = 0;
    vram_ok = 1'b0;
    vram_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (vram_cs && !rst) begin
        if (!r_cs || vram_addr != r_addr) begin
          cnt = 0;
          dly = int'($urandom_range(ok_max, ok_min));
        end else begin
          cnt++;
        end
        vram_ok = (cnt >= dly);
        vram_data = vram_ok ? vmem[vram_addr] : 16'($urandom);
      end else begin
        vram_ok = 1'b0;
        vram_data = 16'($urandom);
      end
      r_cs = vram_cs && !rst;
      r_addr = vram_addr;
    end
  end

  // Monitor: palette writes and done pulses against the scoreboard
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_cs = 1'b0;
      end else begin
        if (vram_cs) cs_cnt++;
        if (vram_cs && mon_cs) check("vram_addr_stable", 64'(vram_addr), 64'(mon_addr));
        mon_cs = vram_cs;
        mon_addr = vram_addr;
        if (pal_we) begin
          words_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_write", 64'({pal_addr, pal_data}), 64'hFFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("pal_write", 64'({pal_addr, pal_data}), 64'({e.addr, e.data}));
          end
        end
        if (done) begin
          done_cnt++;
          check("done_expected", 64'(done_exp > 0), 64'd1);
          if (done_exp > 0) done_exp--;
        end
      end
    end
  end

  initial begin
    int d0, w0, c0;
    for (int a = 0; a < 131072; a++) vmem[a] = 16'($urandom);
    rst = 1'b1;
    pal_copy = 1'b0;
    pal_base = 16'h0000;
    pal_page_en = '0;
    #1;
    check("reset_outputs", 64'({busy, done, vram_cs, vram_addr, pal_we, pal_addr, pal_data}), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // single page 0 from 0x2000, ok one cycle after REQ
    pal_base = 16'h0040;
    pal_page_en = 6'b000001;
    d0 = done_cnt;
    push_copy();
    start_copy();
    wait_idle("t1", 20000);
    check("t1_done_count", 64'(done_cnt - d0), 64'd1);

    // pages 2 and 5, immediate ok
    ok_min = 0; ok_max = 0;
    pal_page_en = 6'b100100;
    push_copy();
    start_copy();
    wait_idle("t2", 20000);

    // request queued mid-copy, extra request dropped, shadowed registers
    pal_base = 16'h0123;
    pal_page_en = 6'b000010;
    d0 = done_cnt;
    w0 = words_seen;
    push_copy();
    start_copy();
    pal_base = 16'h0200;
    pal_page_en = 6'b001001;
    wait_words(w0 + 200);
    push_copy();
    start_copy();
    wait_words(w0 + 300);
    start_copy();
    wait_idle("t3", 40000);
    check("t3_done_count", 64'(done_cnt - d0), 64'd2);

    // reset in the middle of page 0, then restart from the base
    ok_min = 1; ok_max = 3;
    pal_base = 16'h0040;
    pal_page_en = 6'b000001;
    w0 = words_seen;
    push_copy();
    start_copy();
    wait_words(w0 + 100);
    rst = 1'b1;
    #1;
    check("t4_reset_outputs", 64'({busy, done, vram_cs, vram_addr, pal_we, pal_addr, pal_data}), 64'd0);
    exp_q.delete();
    done_exp = 0;
    @(negedge clk);
    rst = 1'b0;
    push_copy();
    start_copy();
    wait_idle("t4", 20000);

    // random ok latency, source wrapping past 0x1FFFF
    ok_min = 0; ok_max = 20;
    pal_base = {6'($urandom), 10'h3FF};
    pal_page_en = 6'b010001;
    push_copy();
    start_copy();
    wait_idle("t5", 60000);

    // empty mask: done two cycles after the edge, no traffic
    ok_min = 1; ok_max = 1;
    pal_page_en = 6'b000000;
    c0 = cs_cnt;
    w0 = words_seen;
    @(negedge clk);
    pal_copy = 1'b1;
    done_exp++;
    @(negedge clk);
    pal_copy = 1'b0;
    check("t6_busy_after_edge", 64'(busy), 64'd1);
    check("t6_done_early", 64'(done), 64'd0);
    @(negedge clk);
    check("t6_done_at_2", 64'(done), 64'd1);
    wait_idle("t6", 100);
    check("t6_no_vram_cs", 64'(cs_cnt - c0), 64'd0);
    check("t6_no_writes", 64'(words_seen - w0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
